conv2d_seq_engine: RTL
======================

// Module: conv2d_seq_engine
// PURPOSE
//  Sequential, parametrised 2-D "same"-padded convolution over one feature map.
//  - Latches an IMG_H x IMG_W image and a K x K kernel on start.
//  - For each output pixel in raster order, accumulates one tap per cycle with zero padding.
//  - Shifts and saturates the result, then streams it out over a valid/ready handshake.
//  - Feeds the pooling/dense stages of the MNIST datapath. Supersedes the fixed 14x14/5x5 combinational window.
// PARAMETERS
//  IMG_H      14  image rows
//  IMG_W      14  image columns
//  K           5  kernel side; must be odd, PAD = K/2
//  INT_SIZE    8  element width; pixels unsigned, kernel taps and output signed
//  OUT_SHIFT   0  arithmetic right shift applied to the accumulator before saturation
// PORTS
//  clk        in   1                      clock, rising edge
//  rst_n      in   1                      asynchronous active-low reset
//  start      in   1                      begin a frame; honoured only in IDLE
//  img        in   IMG_H*IMG_W*INT_SIZE   pixel p=r*IMG_W+c at [p*INT_SIZE +: INT_SIZE]
//  kernel     in   K*K*INT_SIZE           tap t=i*K+j at [(K*K-1-t)*INT_SIZE +: INT_SIZE] (tap 0 in MSBs)
//  busy       out  1                      high from the cycle after start until done
//  out_valid  out  1                      out_data/out_idx hold a result
//  out_ready  in   1                      consumer accepts when out_valid && out_ready
//  out_data   out  INT_SIZE               signed, saturated result
//  out_idx    out  $clog2(IMG_H*IMG_W)    raster index of out_data
//  done       out  1                      1-cycle pulse after the last pixel is accepted
// BEHAVIOUR
//  - Single clock domain. Reset is asynchronous and active-low.
//  - On reset: state=IDLE, busy=0, out_valid=0, out_data=0, out_idx=0, done=0, accumulator=0.
//  - States:
//    - IDLE: on start, register img and kernel, clear row/col/tap counters and accumulator, go to MAC.
//    - MAC: K*K cycles, one tap t per cycle. Source coordinate is (r+i-PAD, c+j-PAD).
//      Bounds are checked on signed coordinates one bit wider than the counters; any tap outside [0,IMG_H-1]x[0,IMG_W-1] adds 0.
//      After tap K*K-1, go to EMIT.
//    - EMIT: out_valid=1. out_data and out_idx stay stable until the handshake completes.
//      On handshake: if idx==IMG_H*IMG_W-1, pulse done and go to IDLE; otherwise advance col (wrap to 0, row+1), clear the accumulator, go to MAC.
//  - Latency: the first out_valid appears K*K+1 cycles after the start cycle. Steady state is K*K+1 cycles per pixel with out_ready held high.
//  - Arithmetic:
//    - Each product is zero-extended pixel x signed tap, 2*INT_SIZE+1 bits.
//    - Accumulator width is 2*INT_SIZE+1+$clog2(K*K), signed, with no overflow possible.
//    - Result = acc >>> OUT_SHIFT, saturated to [-2^(INT_SIZE-1), 2^(INT_SIZE-1)-1].
//  - start while busy is ignored. img and kernel may change freely after the start cycle.
//  - out_ready is ignored while out_valid=0.
//  - Reset mid-frame aborts immediately, with no done pulse. The next start restarts at idx 0.
// CONFIGURATION
//  CONV_RELU_EN defined:
//    - negative saturated results are replaced by 0, so out_data is in [0, 2^(INT_SIZE-1)-1];
//    - applied after the shift; latency is unchanged.
//  CONV_RELU_EN undefined: the signed saturated result is output unchanged.
// STRUCTURE
//  - Shared package conv_pkg holds:
//    - state enum typedef {IDLE, MAC, EMIT};
//    - localparam helper functions for accumulator width and index width;
//    - saturation bounds as functions of INT_SIZE.
//  - Sub-module conv_mac (INT_SIZE, ACC_W): registered accumulator taking clear, enable, unsigned pixel and signed tap.
//    It outputs acc; the shift, saturation and ReLU stay in the parent.
//  - The parent holds the FSM, the row/col/tap counters, the image and kernel registers and the tap mux.
// TESTING  (defaults 14x14, K=5, INT_SIZE=8, OUT_SHIFT=0)
//  1. Image all 1, kernel centre tap 12 = 1 and others 0, out_ready=1:
//     - 196 results, each equal to 1, idx 0..195 in order;
//     - first out_valid at start+26; done exactly once, after idx 195.
//  2. Image all 1, kernel all 1: idx 0 (corner) -> 9; idx 7 (top edge) -> 15; idx 105 (r7,c7) -> 25; idx 195 -> 9.
//  3. Image all 255, kernel all 127 -> every result 127. Kernel all -128 -> -128, or 0 with CONV_RELU_EN.
//     With OUT_SHIFT=4, image all 1 and kernel all 1 -> interior result 1.
//  4. Hold out_ready=0 for 10 cycles while idx=5 is valid:
//     - out_valid stays 1; out_data and out_idx stay stable; no counter advances;
//     - after release, idx 6 follows K*K+1 cycles later.
//  5. Pulse start again at idx 20 -> ignored: the frame completes normally with a single done.
//  6. Assert rst_n=0 asynchronously mid-MAC at idx 50:
//     - busy, out_valid and done go to 0 immediately;
//     - a new start with a new image produces idx 0 first, with correct values.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared state type, width helpers and saturation bounds for conv2d_seq_engine
package conv_pkg;

    typedef enum logic [1:0] {IDLE, MAC, EMIT} state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int acc_width(input int int_size, input int k);
        return 2 * int_size + 1 + $clog2(k * k);
    endfunction

    function automatic int idx_width(input int h, input int w);
        return cnt_width(h * w);
    endfunction

    function automatic int sat_max(input int int_size);
        return (1 << (int_size - 1)) - 1;
    endfunction

    function automatic int sat_min(input int int_size);
        return -(1 << (int_size - 1));
    endfunction

endpackage

// File: rtl/conv_mac.sv
// conv_mac: registered accumulator of unsigned pixel x signed tap products
module conv_mac
    import conv_pkg::*;
#(
    parameter int INT_SIZE = 8,
    parameter int ACC_W    = acc_width(8, 5)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       en,
    input  logic [INT_SIZE-1:0]        pix,
    input  logic signed [INT_SIZE-1:0] tap,
    output logic signed [ACC_W-1:0]    acc
);

    localparam int PW = 2 * INT_SIZE + 1;

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] acc_d, acc_q;

    // zero-extend the pixel so it multiplies as a non-negative signed value
    always_comb begin
        prod  = PW'($signed({1'b0, pix})) * PW'(tap);
        acc_d = clear ? '0 : en ? acc_q + ACC_W'(prod) : acc_q;
    end

    // accumulator register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end

    assign acc = acc_q;

endmodule

// File: rtl/conv2d_seq_engine.sv
// conv2d_seq_engine: sequential same-padded 2-D convolution, one tap per cycle, valid/ready output
// Build option: define CONV_RELU_EN to replace negative results with zero.
module conv2d_seq_engine
    import conv_pkg::*;
#(
    parameter int IMG_H     = 14,
    parameter int IMG_W     = 14,
    parameter int K         = 5,
    parameter int INT_SIZE  = 8,
    parameter int OUT_SHIFT = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [IMG_H*IMG_W*INT_SIZE-1:0]      img,
    input  logic [K*K*INT_SIZE-1:0]              kernel,
    output logic                                 busy,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic signed [INT_SIZE-1:0]           out_data,
    output logic [idx_width(IMG_H, IMG_W)-1:0]   out_idx,
    output logic                                 done
);

    localparam int NPIX  = IMG_H * IMG_W;
    localparam int PAD   = K / 2;
    localparam int ACC_W = acc_width(INT_SIZE, K);
    localparam int IW    = idx_width(IMG_H, IMG_W);
    localparam int RW    = cnt_width(IMG_H);
    localparam int CW    = cnt_width(IMG_W);
    localparam int TW    = cnt_width(K);
    localparam int KW    = cnt_width(K * K);
    localparam int SW    = cnt_width(IMG_H + IMG_W + K) + 1;
    localparam logic [IW-1:0]           LAST = IW'(NPIX - 1);
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(sat_max(INT_SIZE));
    localparam logic signed [ACC_W-1:0] MINV = ACC_W'(sat_min(INT_SIZE));

    state_t                      state_q, state_d;
    logic [RW-1:0]               row_q, row_d;
    logic [CW-1:0]               col_q, col_d;
    logic [TW-1:0]               ti_q, ti_d, tj_q, tj_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic                        busy_q, busy_d, valid_q, valid_d, done_q, done_d;
    logic                        clear, en, load;
    logic [INT_SIZE-1:0]         img_q [NPIX];
    logic signed [INT_SIZE-1:0]  kern_q [K*K];
    logic signed [SW-1:0]        sr, sc;
    logic                        inb;
    logic [IW-1:0]               pidx;
    logic [KW-1:0]               tidx;
    logic [INT_SIZE-1:0]         pix;
    logic signed [INT_SIZE-1:0]  tap, sat;
    logic signed [ACC_W-1:0]     acc, shifted, clamped;

    assign load = (state_q == IDLE) && start;

    // capture the frame so img/kernel may change once it is accepted
    always_ff @(posedge clk) begin
        if (load) begin
            for (int p = 0; p < NPIX; p++) img_q[p] <= img[p*INT_SIZE +: INT_SIZE];
            for (int t = 0; t < K*K; t++) kern_q[t] <= kernel[(K*K-1-t)*INT_SIZE +: INT_SIZE];
        end
    end

    // tap mux: source pixel for the current tap, zero outside the image
    always_comb begin
        sr   = SW'(row_q) + SW'(ti_q) - SW'(PAD);
        sc   = SW'(col_q) + SW'(tj_q) - SW'(PAD);
        inb  = !sr[SW-1] && !sc[SW-1] && (sr < SW'(IMG_H)) && (sc < SW'(IMG_W));
        pidx = inb ? IW'(int'(sr) * IMG_W + int'(sc)) : '0;
        tidx = KW'(int'(ti_q) * K + int'(tj_q));
        pix  = inb ? img_q[pidx] : '0;
        tap  = kern_q[tidx];
    end

    conv_mac #(.INT_SIZE(INT_SIZE), .ACC_W(ACC_W)) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .en    (en),
        .pix   (pix),
        .tap   (tap),
        .acc   (acc)
    );

    // shift, saturate and optionally rectify; acc is frozen while in EMIT
    always_comb begin
        shifted = acc >>> OUT_SHIFT;
        clamped = (shifted > MAXV) ? MAXV : (shifted < MINV) ? MINV : shifted;
        sat     = INT_SIZE'(clamped);
`ifdef CONV_RELU_EN
        out_data = sat[INT_SIZE-1] ? '0 : sat;
`else
        out_data = sat;
`endif
    end

    // next-state logic: IDLE -> MAC (K*K taps) -> EMIT (wait for handshake)
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        ti_d    = ti_q;
        tj_d    = tj_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        clear   = 1'b0;
        en      = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = MAC;
                busy_d  = 1'b1;
                clear   = 1'b1;
                row_d   = '0;
                col_d   = '0;
                ti_d    = '0;
                tj_d    = '0;
                idx_d   = '0;
            end
            MAC: begin
                en   = 1'b1;
                tj_d = (tj_q == TW'(K-1)) ? '0 : tj_q + TW'(1);
                ti_d = (tj_q != TW'(K-1)) ? ti_q : (ti_q == TW'(K-1)) ? '0 : ti_q + TW'(1);
                if (tj_q == TW'(K-1) && ti_q == TW'(K-1)) begin
                    state_d = EMIT;
                    valid_d = 1'b1;
                end
            end
            EMIT: if (out_ready) begin
                valid_d = 1'b0;
                clear   = 1'b1;
                if (idx_q == LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = MAC;
                    idx_d   = idx_q + IW'(1);
                    col_d   = (col_q == CW'(IMG_W-1)) ? '0 : col_q + CW'(1);
                    row_d   = (col_q == CW'(IMG_W-1)) ? row_q + RW'(1) : row_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, counters and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            ti_q    <= '0;
            tj_q    <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            ti_q    <= ti_d;
            tj_q    <= tj_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out_idx   = idx_q;
    assign done      = done_q;

endmodule
